// File: rtl/onn_convergence_monitor.sv
// Oscillator-network settle detector: declares convergence after QUIET_CYCLES change-free cycles, or a timeout at MAX_CYCLES.
// Optional ONN_CONV_MASK_EN adds neuron_mask to exclude neurons from the quiet test and the event count.
module onn_convergence_monitor #(
  parameter int N_NEURONS    = 16,
  parameter int QUIET_CYCLES = 64,
  parameter int MAX_CYCLES   = 4096,
  parameter int EVT_W        = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [N_NEURONS-1:0]                  state_changed,
`ifdef ONN_CONV_MASK_EN
  input  logic [N_NEURONS-1:0]                  neuron_mask,
`endif
  output logic                                  busy,
  output logic                                  converged,
  output logic                                  timeout,
  output logic                                  done,
  output logic [$clog2(QUIET_CYCLES+1)-1:0]     quiet_cnt,
  output logic [$clog2(MAX_CYCLES+1)-1:0]       run_cnt,
  output logic [EVT_W-1:0]                      event_cnt
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int RW = $clog2(MAX_CYCLES + 1);
  localparam int PW = $clog2(N_NEURONS + 1);
  localparam int SW = ((EVT_W > PW) ? EVT_W : PW) + 1;

  typedef enum logic [1:0] {IDLE, RUN, CONVERGED, TIMEOUT} state_t;
  state_t state;

  logic [N_NEURONS-1:0] active;
  logic [PW-1:0]        pop;
  logic [SW-1:0]        evt_sum;
  logic                 quiet;
  logic                 conv_hit;
  logic                 budget_hit;

  always_comb begin
`ifdef ONN_CONV_MASK_EN
    active = state_changed & ~neuron_mask;
`else
    active = state_changed;
`endif
    pop = '0;
    for (int unsigned i = 0; i < N_NEURONS; i++) begin
      pop = pop + PW'(active[i]);
    end
    quiet      = ~|active;
    evt_sum    = SW'(event_cnt) + SW'(pop);
    conv_hit   = quiet && (quiet_cnt == QW'(QUIET_CYCLES - 1));
    budget_hit = (run_cnt == RW'(MAX_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      converged <= 1'b0;
      timeout   <= 1'b0;
      done      <= 1'b0;
      quiet_cnt <= '0;
      run_cnt   <= '0;
      event_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            run_cnt   <= run_cnt + 1'b1;
            event_cnt <= (evt_sum > SW'({EVT_W{1'b1}})) ? '1 : evt_sum[EVT_W-1:0];
            // Convergence is tested first so it wins over a coincident budget expiry.
            if (conv_hit) begin
              quiet_cnt <= QW'(QUIET_CYCLES);
              state     <= CONVERGED;
              converged <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b0;
            end else begin
              quiet_cnt <= quiet ? quiet_cnt + 1'b1 : '0;
              if (budget_hit) begin
                state   <= TIMEOUT;
                timeout <= 1'b1;
                done    <= 1'b1;
                busy    <= 1'b0;
              end
            end
          end
        end
        // IDLE shares this branch: its flags are already clear, so abort is a no-op there.
        IDLE, CONVERGED, TIMEOUT: begin
          if (abort) begin
            state     <= IDLE;
            converged <= 1'b0;
            timeout   <= 1'b0;
          end else if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            converged <= 1'b0;
            timeout   <= 1'b0;
            quiet_cnt <= '0;
            run_cnt   <= '0;
            event_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onn_convergence_monitor.sv
// Randomized bench for onn_convergence_monitor against a quiet-streak/event-total model; a 4-bit event-count copy covers saturation.
module tb_onn_convergence_monitor;

  localparam int Q = 64;
  localparam int M = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] sc = '0;
  logic [15:0] mask = '0;

  logic        busy, converged, timeout, done;
  logic [6:0]  quiet_cnt;
  logic [12:0] run_cnt;
  logic [15:0] event_cnt;
  logic        busy4, converged4, timeout4, done4;
  logic [6:0]  quiet_cnt4;
  logic [12:0] run_cnt4;
  logic [3:0]  event_cnt4;

  int errors = 0;
  int checks = 0;

  onn_convergence_monitor #(.N_NEURONS(16), .QUIET_CYCLES(Q), .MAX_CYCLES(M), .EVT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .state_changed(sc),
`ifdef ONN_CONV_MASK_EN
    .neuron_mask(mask),
`endif
    .busy(busy), .converged(converged), .timeout(timeout), .done(done),
    .quiet_cnt(quiet_cnt), .run_cnt(run_cnt), .event_cnt(event_cnt)
  );

  onn_convergence_monitor #(.N_NEURONS(16), .QUIET_CYCLES(Q), .MAX_CYCLES(M), .EVT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .state_changed(sc),
`ifdef ONN_CONV_MASK_EN
    .neuron_mask(mask),
`endif
    .busy(busy4), .converged(converged4), .timeout(timeout4), .done(done4),
    .quiet_cnt(quiet_cnt4), .run_cnt(run_cnt4), .event_cnt(event_cnt4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: quiet streak = samples since the last active sample; events are an unbounded total clipped per width.
  bit m_run, m_conv, m_to, m_done;
  int m_cnt, m_last, m_ev;
  bit prev_done;

  always @(posedge clk or posedge rst) begin
    m_done = 1'b0;
    if (rst) begin
      m_run = 0; m_conv = 0; m_to = 0; m_cnt = 0; m_last = 0; m_ev = 0;
    end else if (m_run) begin
      if (abort) begin
        m_run = 0;
      end else begin
        m_cnt++;
`ifdef ONN_CONV_MASK_EN
        if ((sc & ~mask) != 0) m_last = m_cnt;
        m_ev += $countones(sc & ~mask);
`else
        if (sc != 0) m_last = m_cnt;
        m_ev += $countones(sc);
`endif
        if (m_cnt - m_last == Q) begin
          m_conv = 1; m_run = 0; m_done = 1;
        end else if (m_cnt == M) begin
          m_to = 1; m_run = 0; m_done = 1;
        end
      end
    end else if (abort) begin
      m_conv = 0; m_to = 0;
    end else if (start) begin
      m_run = 1; m_conv = 0; m_to = 0; m_cnt = 0; m_last = 0; m_ev = 0;
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_run);
    check("converged", converged, m_conv);
    check("timeout", timeout, m_to);
    check("done", done, m_done);
    check("quiet_cnt", quiet_cnt, m_cnt - m_last);
    check("run_cnt", run_cnt, m_cnt);
    check("event_cnt", event_cnt, (m_ev > 65535) ? 65535 : m_ev);
    check("event_cnt4", event_cnt4, (m_ev > 15) ? 15 : m_ev);
    check("converged4", converged4, m_conv);
    check("timeout4", timeout4, m_to);
    check("done_repeat", prev_done & done, 0);
    check("aux4", {busy4, done4, quiet_cnt4, run_cnt4}, {m_run, m_done, 7'(m_cnt - m_last), 13'(m_cnt)});
    prev_done = done;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int dens;
    #1 rst = 1'b1;
    step(2);
    check("reset_busy", busy, 0);
    check("reset_flags", {converged, timeout, done}, 0);
    check("reset_counts", {quiet_cnt, run_cnt, event_cnt}, 0);
    rst = 1'b0;

    // Quiet run: converged right after edge Q
    start = 1'b1; step(1); start = 1'b0;
    check("quiet_busy", busy, 1);
    step(63);
    check("quiet_conv_early", converged, 0);
    step(1);
    check("quiet_conv", converged, 1);
    check("quiet_done", done, 1);
    check("quiet_run_cnt", run_cnt, 64);
    check("quiet_events", event_cnt, 0);
    check("quiet_qcnt", quiet_cnt, 64);
    step(1);
    check("quiet_done_clear", done, 0);

    // Late activity at RUN cycle 50
    start = 1'b1; step(1); start = 1'b0;
    step(49);
    sc = 16'h0008; step(1); sc = '0;
    check("late_qcnt_zero", quiet_cnt, 0);
    step(63);
    check("late_conv_early", converged, 0);
    step(1);
    check("late_conv", converged, 1);
    check("late_events", event_cnt, 1);
    check("late_run_cnt", run_cnt, 114);

    // Timeout with periodic activity
    start = 1'b1; step(1); start = 1'b0;
    k = 0;
    while (!done && k < 5000) begin
      k++;
      sc = (k % 10 == 0) ? 16'h0001 : 16'h0000;
      step(1);
    end
    sc = '0;
    check("timeout_edge", k, 4096);
    check("timeout_flag", timeout, 1);
    check("timeout_conv", converged, 0);
    check("timeout_run_cnt", run_cnt, 4096);

    // Popcount saturation, then abort at RUN cycle 20
    start = 1'b1; step(1); start = 1'b0;
    sc = 16'hFFFF; step(2); sc = '0;
    check("sat_events4", event_cnt4, 15);
    check("sat_events16", event_cnt, 32);
    step(17);
    abort = 1'b1; step(1); abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_run_cnt", run_cnt, 19);
    step(3);
    check("abort_frozen", run_cnt, 19);
    check("abort_sat_hold", event_cnt4, 15);
    start = 1'b1; abort = 1'b1; step(1); start = 1'b0; abort = 1'b0;
    check("start_abort_idle", busy, 0);

`ifdef ONN_CONV_MASK_EN
    mask = 16'h0001;
    start = 1'b1; step(1); start = 1'b0;
    for (int i = 0; i < 63; i++) begin
      sc = {15'd0, 1'(i % 2 == 0)}; step(1);
    end
    check("mask_conv_early", converged, 0);
    sc = 16'h0001; step(1); sc = '0;
    check("mask_conv", converged, 1);
    check("mask_events", event_cnt, 0);
    mask = '0;
`endif

    // Randomized traffic with occasional async reset
    dens = 40;
    for (int c = 0; c < 20000; c++) begin
      if (c % 1000 == 0) begin
        case ($urandom_range(0, 2))
          0: dens = 8;
          1: dens = 40;
          default: dens = 400;
        endcase
      end
      start = ($urandom_range(0, 24) == 0);
      abort = ($urandom_range(0, 399) == 0);
      sc = ($urandom_range(0, dens - 1) == 0) ? 16'($urandom) : 16'h0000;
`ifdef ONN_CONV_MASK_EN
      if ($urandom_range(0, 199) == 0) mask = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
`endif
      if ($urandom_range(0, 2999) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        step(1);
      end else begin
        step(1);
      end
    end
    start = 1'b0; abort = 1'b0; sc = '0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
